// File: rtl/dac_spi_tx_if.sv
// rtl/dac_spi_tx_if.sv - sample/strobe inputs and SPI/status outputs of dac_spi_tx
// Signals:
//   dac0, dac0_dv   channel A sample and its one-cycle strobe
//   dac1, dac1_dv   channel B sample and its one-cycle strobe
//   busy            transmitter not idle
//   ovr[1:0]        per-channel overwrite pulse
//   spi_cs_n, spi_sclk, spi_mosi, ldac_n   DAC serial port
// Modports: master = sample producer / SPI observer, slave = dac_spi_tx.
interface dac_spi_tx_if;
    logic [11:0] dac0;
    logic        dac0_dv;
    logic [11:0] dac1;
    logic        dac1_dv;
    logic        busy;
    logic [1:0]  ovr;
    logic        spi_cs_n;
    logic        spi_sclk;
    logic        spi_mosi;
    logic        ldac_n;

    modport master (
        output dac0, dac0_dv, dac1, dac1_dv,
        input  busy, ovr, spi_cs_n, spi_sclk, spi_mosi, ldac_n
    );

    modport slave (
        input  dac0, dac0_dv, dac1, dac1_dv,
        output busy, ovr, spi_cs_n, spi_sclk, spi_mosi, ldac_n
    );
endinterface

// File: rtl/dac_spi_tx.sv
// rtl/dac_spi_tx.sv - two-channel 12-bit DAC SPI transmitter with round-robin arbitration
// Ports:
//   clk  system clock, rising edge
//   rst  asynchronous active-high reset
//   bus  dac_spi_tx_if.slave: sample inputs, busy/ovr status, SPI mode-0 outputs, ldac_n
// Parameters:
//   CLK_DIV   SCLK half-period in clk cycles (2..255)
//   CFG_BITS  frame bits [14:12] (BUF, GA_n, SHDN_n)
// Macro DAC_LDAC_EN: when defined, ldac_n is pulsed low after the last frame of a
//   back-to-back burst; otherwise ldac_n is tied low and LATCH is never entered.
module dac_spi_tx #(
    parameter int unsigned CLK_DIV  = 4,
    parameter logic [2:0]  CFG_BITS = 3'b011
) (
    input  logic         clk,
    input  logic         rst,
    dac_spi_tx_if.slave  bus
);

    typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP, LATCH} state_t;

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        half_q, half_d;
    logic [3:0]  bit_q, bit_d;
    logic [15:0] shift_q, shift_d;
    logic [11:0] hold0_q, hold0_d;
    logic [11:0] hold1_q, hold1_d;
    logic [1:0]  pend_q, pend_d;
    logic [1:0]  ovr_q, ovr_d;
    logic        rr_q, rr_d;

    logic        phase_end;
    logic        capture;
    logic        sel;

    // Every phase (SETUP, each SCLK half, HOLD, GAP, LATCH) is CLK_DIV cycles long.
    assign phase_end = (cnt_q == DIV_LAST);
    assign capture   = (state_q == IDLE) && (pend_q != 2'b00);
    // rr_q names the channel that wins a tie; a lone pending channel always wins.
    assign sel       = (pend_q == 2'b11) ? rr_q : pend_q[1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  if (capture) state_d = SETUP;
            SETUP: if (phase_end) state_d = SHIFT;
            SHIFT: if (phase_end && half_q && (bit_q == 4'd15)) state_d = HOLD;
            HOLD:  if (phase_end) state_d = GAP;
            GAP: begin
                if (phase_end) begin
`ifdef DAC_LDAC_EN
                    // rr_q points at the channel not just sent: if it waits, defer the latch
                    // so both outputs update together after its frame.
                    state_d = pend_q[rr_q] ? IDLE : LATCH;
`else
                    state_d = IDLE;
`endif
                end
            end
            LATCH: if (phase_end) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cnt_d   = ((state_q == IDLE) || phase_end) ? 8'd0 : cnt_q + 8'd1;
        half_d  = half_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        rr_d    = rr_q;
        pend_d  = pend_q;
        hold0_d = hold0_q;
        hold1_d = hold1_q;
        ovr_d   = 2'b00;

        if (capture) begin
            shift_d      = {sel, CFG_BITS, sel ? hold1_q : hold0_q};
            pend_d[sel]  = 1'b0;
            rr_d         = ~sel;
            half_d       = 1'b0;
            bit_d        = 4'd0;
        end

        // Data advances only at the end of a high half, i.e. on the SCLK falling edge.
        if ((state_q == SHIFT) && phase_end) begin
            half_d = ~half_q;
            if (half_q) begin
                bit_d   = bit_q + 4'd1;
                shift_d = {shift_q[14:0], 1'b0};
            end
        end

        // A strobe coinciding with capture of the same channel refills the pend
        // instead of counting as an overwrite: the old value is already in flight.
        if (bus.dac0_dv) begin
            ovr_d[0]  = pend_q[0] && !(capture && !sel);
            hold0_d   = bus.dac0;
            pend_d[0] = 1'b1;
        end
        if (bus.dac1_dv) begin
            ovr_d[1]  = pend_q[1] && !(capture && sel);
            hold1_d   = bus.dac1;
            pend_d[1] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q   <= 8'd0;
            half_q  <= 1'b0;
            bit_q   <= 4'd0;
            shift_q <= 16'd0;
            hold0_q <= 12'd0;
            hold1_q <= 12'd0;
            pend_q  <= 2'b00;
            ovr_q   <= 2'b00;
            rr_q    <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            half_q  <= half_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            hold0_q <= hold0_d;
            hold1_q <= hold1_d;
            pend_q  <= pend_d;
            ovr_q   <= ovr_d;
            rr_q    <= rr_d;
        end
    end

    always_comb begin
        bus.busy     = (state_q != IDLE);
        bus.spi_cs_n = !((state_q == SETUP) || (state_q == SHIFT) || (state_q == HOLD));
        bus.spi_sclk = (state_q == SHIFT) && half_q;
        bus.spi_mosi = ((state_q == SETUP) || (state_q == SHIFT)) ? shift_q[15] : 1'b0;
        bus.ovr      = ovr_q;
`ifdef DAC_LDAC_EN
        bus.ldac_n   = (state_q != LATCH);
`else
        bus.ldac_n   = 1'b0;
`endif
    end

endmodule

// File: tb/tb_dac_spi_tx.sv
// tb/tb_dac_spi_tx.sv - testbench for dac_spi_tx (CLK_DIV=4, CFG_BITS=3'b011)
module tb_dac_spi_tx;

    localparam int         C   = 4;
    localparam logic [2:0] CFG = 3'b011;
`ifdef DAC_LDAC_EN
    localparam bit LDAC_EN = 1'b1;
`else
    localparam bit LDAC_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dac_spi_tx_if bus ();

    dac_spi_tx #(.CLK_DIV(C), .CFG_BITS(CFG)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp = n_cmp + 1;
        if (act !== exp) begin
            n_bad = n_bad + 1;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // ---------------- behavioural model: frame timeline from spec rules ----------------
    int          m_mode = 0;   // 0 idle, 1 framing (t counts from cs_n fall), 2 latch
    int          m_t = 0;
    logic [15:0] m_frame = 16'd0;
    logic [1:0]  m_pend = 2'b00;
    logic [1:0]  m_ovr = 2'b00;
    logic [11:0] m_hold [2];
    logic        m_rr = 1'b0;
    logic [1:0]  pend_was;
    logic        cap;
    logic        cap_ch;
    logic        ch;

    always @(posedge clk) begin
        if (rst) begin
            m_mode = 0; m_t = 0; m_pend = 2'b00; m_ovr = 2'b00; m_rr = 1'b0;
            m_hold[0] = 12'd0; m_hold[1] = 12'd0;
        end else begin
            pend_was = m_pend;
            cap = 1'b0;
            cap_ch = 1'b0;
            m_ovr = 2'b00;
            if (m_mode == 0) begin
                if (m_pend != 2'b00) begin
                    ch = (m_pend == 2'b11) ? m_rr : m_pend[1];
                    m_frame = {ch, CFG, m_hold[ch]};
                    m_pend[ch] = 1'b0;
                    m_rr = ~ch;
                    m_mode = 1; m_t = 0;
                    cap = 1'b1; cap_ch = ch;
                end
            end else if (m_mode == 1) begin
                m_t = m_t + 1;
                if (m_t == 35 * C) begin
                    if (LDAC_EN && !m_pend[m_rr]) begin m_mode = 2; m_t = 0; end
                    else m_mode = 0;
                end
            end else begin
                m_t = m_t + 1;
                if (m_t == C) m_mode = 0;
            end
            if (bus.dac0_dv) begin
                m_ovr[0] = pend_was[0] && !(cap && cap_ch == 1'b0);
                m_hold[0] = bus.dac0; m_pend[0] = 1'b1;
            end
            if (bus.dac1_dv) begin
                m_ovr[1] = pend_was[1] && !(cap && cap_ch == 1'b1);
                m_hold[1] = bus.dac1; m_pend[1] = 1'b1;
            end
        end
    end

    // ---------------- per-cycle compare + measurements ----------------
    logic e_cs, e_sclk, e_mosi, e_busy, e_ldac, mchk;
    logic [1:0] e_ovr;
    int u;
    int len_cnt = 0, last_len = 0;
    int ovr_cnt0 = 0, ovr_cnt1 = 0, ldac_low = 0;

    always @(negedge clk) begin
        e_cs = 1'b1; e_sclk = 1'b0; e_mosi = 1'b0; e_busy = 1'b0; mchk = 1'b1;
        e_ldac = LDAC_EN; e_ovr = 2'b00;
        if (!rst) begin
            e_ovr = m_ovr;
            if (m_mode == 1) begin
                e_busy = 1'b1;
                if (m_t < C) begin
                    e_cs = 1'b0; e_mosi = m_frame[15];
                end else if (m_t < 33 * C) begin
                    u = m_t - C;
                    e_cs = 1'b0;
                    e_sclk = ((u % (2 * C)) >= C);
                    e_mosi = m_frame[15 - u / (2 * C)];
                end else if (m_t < 34 * C) begin
                    e_cs = 1'b0; mchk = 1'b0;
                end
            end else if (m_mode == 2) begin
                e_busy = 1'b1; e_ldac = 1'b0;
            end
        end
        check("cs_n", bus.spi_cs_n, e_cs);
        check("sclk", bus.spi_sclk, e_sclk);
        if (mchk) check("mosi", bus.spi_mosi, e_mosi);
        check("busy", bus.busy, e_busy);
        check("ldac_n", bus.ldac_n, e_ldac);
        check("ovr", bus.ovr, e_ovr);

        if (rst) begin
            len_cnt = 0;
        end else begin
            if (bus.busy && !(LDAC_EN && bus.spi_cs_n && !bus.ldac_n)) len_cnt = len_cnt + 1;
            else if (len_cnt > 0) begin last_len = len_cnt; len_cnt = 0; end
            ovr_cnt0 = ovr_cnt0 + int'(bus.ovr[0]);
            ovr_cnt1 = ovr_cnt1 + int'(bus.ovr[1]);
            if (bus.ldac_n === 1'b0) ldac_low = ldac_low + 1;
        end
    end

    // ---------------- SPI sniffer: frames as sampled on SCLK rises ----------------
    logic [15:0] sh = 16'd0;
    int rises = 0, last_rises = 0;
    logic [15:0] sniff_q [$];

    always @(posedge bus.spi_sclk) begin
        sh = {sh[14:0], bus.spi_mosi};
        rises = rises + 1;
    end
    always @(negedge bus.spi_cs_n) begin
        sh = 16'd0; rises = 0;
    end
    always @(posedge bus.spi_cs_n) begin
        if (!rst) begin
            sniff_q.push_back(sh);
            last_rises = rises;
        end
    end

    function automatic logic [31:0] frame_at(input int i);
        if (i < sniff_q.size()) return {16'd0, sniff_q[i]};
        return 32'hFFFF_FFFF;
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic do_reset();
        @(negedge clk); rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        sniff_q.delete();
        ovr_cnt0 = 0; ovr_cnt1 = 0; ldac_low = 0; last_len = 0;
    endtask

    task automatic strobe(input logic v0, input logic [11:0] d0, input logic v1, input logic [11:0] d1);
        @(negedge clk);
        bus.dac0 = d0; bus.dac0_dv = v0; bus.dac1 = d1; bus.dac1_dv = v1;
        @(negedge clk);
        bus.dac0_dv = 1'b0; bus.dac1_dv = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int quiet = 0;
        int n = 0;
        while (quiet < 5 && n < 3000) begin
            @(negedge clk);
            n = n + 1;
            quiet = bus.busy ? 0 : quiet + 1;
        end
        check({name, "_timeout"}, 32'(n >= 3000), 32'd0);
    endtask

    initial begin
        bus.dac0 = 12'd0; bus.dac0_dv = 1'b0; bus.dac1 = 12'd0; bus.dac1_dv = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_cs_n", bus.spi_cs_n, 1);
        check("rst_sclk", bus.spi_sclk, 0);
        check("rst_mosi", bus.spi_mosi, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_ovr", bus.ovr, 0);
        check("rst_ldac", bus.ldac_n, LDAC_EN);
        rst = 1'b0;
        sniff_q.delete();

        // Single write
        strobe(1'b1, 12'hABC, 1'b0, 12'h000);
        wait_idle("t1");
        check("t1_nframes", sniff_q.size(), 1);
        check("t1_frame", frame_at(0), 32'h3ABC);
        check("t1_rises", last_rises, 16);
        check("t1_len", last_len, 140);
`ifdef DAC_LDAC_EN
        check("t1_ldac_low", ldac_low, 4);
`endif

        // Simultaneous strobes after reset: channel 0 first
        do_reset();
        strobe(1'b1, 12'h111, 1'b1, 12'h222);
        wait_idle("t2");
        check("t2_nframes", sniff_q.size(), 2);
        check("t2_frame0", frame_at(0), 32'h3111);
        check("t2_frame1", frame_at(1), 32'hB222);
`ifdef DAC_LDAC_EN
        check("t2_ldac_low", ldac_low, 4);
`endif

        // Overrun of channel 1 during a channel-0 frame
        do_reset();
        strobe(1'b1, 12'h555, 1'b0, 12'h000);
        repeat (10) @(negedge clk);
        strobe(1'b0, 12'h000, 1'b1, 12'h100);
        repeat (10) @(negedge clk);
        strobe(1'b0, 12'h000, 1'b1, 12'h200);
        wait_idle("t3");
        check("t3_ovr1_pulses", ovr_cnt1, 1);
        check("t3_ovr0_pulses", ovr_cnt0, 0);
        check("t3_nframes", sniff_q.size(), 2);
        check("t3_frame0", frame_at(0), 32'h3555);
        check("t3_frame1", frame_at(1), 32'hB200);

        // Round robin with both channels kept pending
        do_reset();
        for (int i = 0; i < 80 && sniff_q.size() < 4; i++) begin
            strobe(1'b1, 12'h0A0, 1'b1, 12'h0B1);
            repeat (18) @(negedge clk);
        end
        wait_idle("t4");
        check("t4_frame0", frame_at(0), 32'h30A0);
        check("t4_frame1", frame_at(1), 32'hB0B1);
        check("t4_frame2", frame_at(2), 32'h30A0);
        check("t4_frame3", frame_at(3), 32'hB0B1);

        // Reset mid-shift after bit 7
        do_reset();
        strobe(1'b1, 12'h5A5, 1'b0, 12'h000);
        begin
            int n = 0;
            while (rises < 8 && n < 400) begin @(negedge clk); n = n + 1; end
            check("t5_reach_bit7", 32'(n >= 400), 32'd0);
        end
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("t5_async_cs_n", bus.spi_cs_n, 1);
        check("t5_async_sclk", bus.spi_sclk, 0);
        check("t5_async_busy", bus.busy, 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        sniff_q.delete();
        repeat (200) @(negedge clk);
        check("t5_no_frame", sniff_q.size(), 0);

        // Capture collision on channel 0
        do_reset();
        @(negedge clk); bus.dac0 = 12'h123; bus.dac0_dv = 1'b1;
        @(negedge clk); bus.dac0 = 12'h456;
        @(negedge clk); bus.dac0_dv = 1'b0;
        wait_idle("t6");
        check("t6_ovr0_pulses", ovr_cnt0, 0);
        check("t6_frame0", frame_at(0), 32'h3123);
        check("t6_frame1", frame_at(1), 32'h3456);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/dac_spi_tx.md
DAC_SPI_TX -- requirements
Module: dac_spi_tx

Interface
REQ-001 Parameter CLK_DIV, default 4: SCLK half-period in clk cycles; legal range 2..255.
REQ-002 Parameter CFG_BITS, default 3'b011: frame bits [14:12] (BUF, GA_n, SHDN_n).
REQ-003 clk  input  1  system clock; all logic on rising edge.
REQ-004 rst  input  1  reset; asynchronous, active-high.
REQ-005 dac0  input  12  channel A sample.
REQ-006 dac0_dv  input  1  one-cycle strobe qualifying dac0.
REQ-007 dac1  input  12  channel B sample.
REQ-008 dac1_dv  input  1  one-cycle strobe qualifying dac1.
REQ-009 busy  output  1  high whenever state is not IDLE.
REQ-010 ovr  output  2  one-cycle pulse per channel when a pending sample is overwritten before transmission.
REQ-011 spi_cs_n  output  1  DAC chip select, active-low.
REQ-012 spi_sclk  output  1  SPI clock, mode 0, idles low.
REQ-013 spi_mosi  output  1  serial data, MSB first.
REQ-014 ldac_n  output  1  DAC latch strobe, active-low.

Function
REQ-015 Each channel SHALL have a 12-bit holding register and pend flag; dvN loads the register and sets pendN in the same cycle.
REQ-016 A dvN arriving while pendN=1 SHALL overwrite the data (latest wins) and pulse ovr[N] for one cycle.
REQ-017 States SHALL be IDLE, SETUP, SHIFT, HOLD, GAP, LATCH.
REQ-018 IDLE: if any pend set, select a channel, load 16-bit shift register {ch, CFG_BITS, data}, clear that pend, drive spi_cs_n low, go to SETUP.
REQ-019 Arbitration SHALL be round-robin: the channel not sent last wins when both are pending; after reset channel 0 wins.
REQ-020 A dvN in the same cycle its pend is cleared for capture SHALL leave pendN set with the new data, without pulsing ovr.
REQ-021 SETUP lasts CLK_DIV cycles with spi_mosi = frame bit 15 and spi_sclk low.
REQ-022 SHIFT SHALL produce 16 SCLK periods of 2*CLK_DIV cycles: low half, then high half; spi_mosi changes only at the falling edge (end of high half).
REQ-023 HOLD lasts CLK_DIV cycles after the 16th falling edge with spi_cs_n low; spi_cs_n then goes high.
REQ-024 GAP holds spi_cs_n high for CLK_DIV cycles, then goes to LATCH or IDLE per REQ-029/REQ-030.
REQ-025 Frame length from spi_cs_n fall to IDLE SHALL be (35*CLK_DIV) cycles excluding LATCH (140 at CLK_DIV=4).
REQ-026 spi_mosi SHALL be 0 and spi_sclk 0 whenever spi_cs_n is high.
REQ-027 Channel bit 15: 0 = dac0 (A), 1 = dac1 (B); data occupies bits [11:0].

Reset
REQ-028 On rst asserted, at any time including mid-frame: state IDLE, pends cleared, holding registers 0, spi_cs_n=1, spi_sclk=0, spi_mosi=0, ldac_n=1, busy=0, ovr=0, round-robin pointer to channel 0; partial frames are abandoned, not resumed.

Configuration
REQ-029 With DAC_LDAC_EN defined: after GAP, if the other channel is pending go directly to IDLE-arbitration (no latch); otherwise enter LATCH, drive ldac_n low CLK_DIV cycles, return to IDLE. Both outputs thus update together when back-to-back.
REQ-030 Without DAC_LDAC_EN: ldac_n SHALL be constant 0, LATCH state unreachable, GAP always returns to IDLE.

Verification
REQ-031 Single write: dac0=12'hABC, dac0_dv pulse, CLK_DIV=4 -> one frame, MOSI 16'h3ABC, 16 SCLK rises, frame 140 cycles; with DAC_LDAC_EN ldac_n low 4 cycles after GAP.
REQ-032 Simultaneous dac0_dv (12'h111) and dac1_dv (12'h222) -> frames 16'h3111 then 16'hB222 back-to-back; with DAC_LDAC_EN exactly one ldac_n pulse, after second frame.
REQ-033 Overrun: dac1_dv 12'h100 then 12'h200 during an active channel-0 frame -> ovr[1] single pulse on second strobe; channel-1 frame carries 16'hB200 only.
REQ-034 Round-robin: both channels continuously pending for 4 frames -> channel order 0,1,0,1.
REQ-035 Reset mid-SHIFT (after bit 7): rst asserted -> spi_cs_n high, sclk low, busy low asynchronously; after release no frame until a new dv.
REQ-036 Capture-collision: dac0_dv coincident with IDLE capture of channel 0 -> current frame sends old value, next frame sends new value, ovr[0] stays 0.
